neo_spike_detector: RTL and testbench
=====================================

NEO_SPIKE_DETECTOR -- requirements
Module: neo_spike_detector

Interface
REQ-001 SHALL have parameter MEAN_SHIFT, default 8, which sets the running-mean time constant as a right-shift amount.
REQ-002 SHALL have parameter WARMUP_LEN, default 256, which is the number of psi results gated off after reset.
REQ-003 SHALL have the port list below.
  clk  in  1  sole clock, rising edge.
  reset  in  1  synchronous, active-high.
  sample_in  in  16  signed neural sample.
  sample_valid  in  1  sample_in accepted this cycle.
  thresh_scale_in  in  8  threshold multiplier, unsigned, units of 1/4.
  min_thresh_in  in  16  threshold floor, unsigned, zero-extended to 32 bits.
  refractory_in  in  16  detection lockout, counted in valid samples.
  current_detection  out  1  one-clk detection pulse; drives the classifier current_detection input.
  neo_energy  out  32  last clamped psi, unsigned.
  neo_valid  out  1  one-clk pulse; neo_energy updated.

Function
REQ-004 SHALL use a 3-stage pipeline, with a valid bit carried per stage.
- S1: on sample_valid, shift history x2<=x1, x1<=x0, x0<=sample_in.
- S2: compute psi.
- S3: compare, run refractory logic, update the mean.
REQ-005 SHALL hold all pipeline state during cycles with sample_valid=0; gaps SHALL NOT create pulses.
REQ-006 SHALL assert current_detection and neo_valid exactly 3 clk after the accepting sample_valid cycle (T accept -> high in T+3), each for one clk.
REQ-007 SHALL compute psi = x1*x1 - x0*x2 on signed products in at least 33-bit signed arithmetic.
REQ-008 SHALL clamp negative psi to 0; the result SHALL be an unsigned 32-bit value that never overflows (max < 2^31).
REQ-009 SHALL produce no psi until 3 samples have been accepted since reset; the first neo_valid SHALL follow the 3rd sample.
REQ-010 SHALL keep a 40-bit accumulator acc, updated once per psi in S3:
- update: acc <= acc - (acc >> MEAN_SHIFT) + psi;
- mean = acc >> MEAN_SHIFT, truncated to 32 bits.
REQ-011 SHALL compute thr = (mean * thresh_scale_in) >> 2 in 40-bit arithmetic, then set threshold = max(thr, min_thresh_in).
REQ-012 SHALL evaluate each psi against the mean as it stood before that psi updates acc.
REQ-013 SHALL declare a detection candidate when psi > threshold (strict); psi equal to threshold SHALL NOT detect.
REQ-014 SHALL gate off detection for the first WARMUP_LEN psi results; acc SHALL still update during warm-up.
REQ-015 SHALL run a 16-bit refractory counter:
- a detection loads it with refractory_in;
- each subsequent psi decrements it while it is nonzero;
- a candidate SHALL be suppressed while the counter is nonzero;
- refractory_in=0 SHALL impose no lockout.
REQ-016 SHALL continue to update acc during refractory and suppressed cycles.
REQ-017 SHALL sample thresh_scale_in, min_thresh_in and refractory_in live in the S3 cycle; no shadow registers.
REQ-018 SHALL have thresh_scale_in=0 force threshold = min_thresh_in.
REQ-019 SHALL have the warm-up counter saturate at WARMUP_LEN with no wrap.
REQ-020 SHALL make sample_valid in the same cycle as reset have no effect.

Reset
REQ-021 SHALL, on a clk edge with reset=1, clear all of the following:
- current_detection=0, neo_valid=0, neo_energy=0;
- x0/x1/x2=0, all stage valid bits, acc, warm-up counter, refractory counter.
REQ-022 SHALL discard in-flight pipeline data on a mid-stream reset; no pulse SHALL appear after reset deasserts until a new 3-sample history and warm-up complete.

Verification
REQ-023 SHALL cover the following directed scenarios:
- Constant 1000, 400 samples -> every neo_energy=0, current_detection never high.
- 300 zero samples, then 0,50,0,0; min_thresh_in=100, scale=8 -> psi=2500 when x1=50 -> exactly one current_detection pulse, 3 clk after the sample following 50.
- Sequence 100,0,100 after warm-up -> raw psi=-10000 -> neo_energy=0, no detection.
- Two 50-impulses 5 samples apart: refractory_in=10 -> 1 pulse; refractory_in=2 -> 2 pulses.
- Impulse at psi index 200 (inside warm-up) -> no pulse; same impulse at index 300 -> pulse.
- Reset asserted 1 clk after impulse accept -> no pulse in the next 3 clk; all outputs 0.

Source files
------------

// File: rtl/neo_spike_detector.sv
// neo_spike_detector
//   Nonlinear energy operator (NEO) spike detector. Each accepted sample
//   shifts a 3-deep history; psi = x1^2 - x0*x2 is clamped at zero and
//   compared against an adaptive threshold derived from a leaky running
//   mean of psi. Detections are gated during warm-up and by a refractory
//   lockout counted in psi results.
//
// Ports
//   clk               rising-edge clock
//   reset             synchronous, active-high
//   sample_in         signed 16-bit neural sample
//   sample_valid      sample_in accepted this cycle
//   thresh_scale_in   threshold multiplier, unsigned, units of 1/4
//   min_thresh_in     threshold floor, unsigned
//   refractory_in     lockout length in psi results after a detection
//   current_detection one-clk detection pulse
//   neo_energy        last clamped psi
//   neo_valid         one-clk pulse, neo_energy updated
//
// Latency: a sample accepted in cycle T produces its outputs in cycle T+3.

module neo_spike_detector #(
  parameter int MEAN_SHIFT = 8,
  parameter int WARMUP_LEN = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  input  logic [7:0]  thresh_scale_in,
  input  logic [15:0] min_thresh_in,
  input  logic [15:0] refractory_in,
  output logic        current_detection,
  output logic [31:0] neo_energy,
  output logic        neo_valid
);

  localparam int STAGES = 3;
  localparam int WARM_W = (WARMUP_LEN < 1) ? 1 : $clog2(WARMUP_LEN + 1);

  // vld_pipe[1]: history holds a full triple for psi
  // vld_pipe[2]: psi_q holds a fresh psi
  // vld_pipe[3]: outputs updated this cycle
  logic [STAGES:1] vld_pipe;
  logic            s1_fire;

  logic [1:0]  hist_cnt;
  logic [15:0] x0, x1, x2;
  logic [31:0] psi_q;

  logic [39:0]       acc;
  logic [WARM_W-1:0] warm_cnt;
  logic [15:0]       refr_cnt;

  logic signed [33:0] x0e, x1e, x2e, sq, cr, psi_raw;
  logic [31:0] psi_clamp;
  logic [39:0] acc_sh, acc_next;
  logic [31:0] mean;
  logic [39:0] thr_prod, thr, floor40, threshold;
  logic        candidate, warm_done, detect;
  logic        unused_ok;

  // A sample becomes psi-eligible only once two earlier samples are held.
  assign s1_fire   = sample_valid && (hist_cnt == 2'd2);
  assign neo_valid = vld_pipe[STAGES];

  // Valid shift register; idle cycles insert bubbles, so gaps never pulse.
  always_ff @(posedge clk) begin
    if (reset) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[STAGES-1:1], s1_fire};
  end

  // S1: sample history, held across gaps
  always_ff @(posedge clk) begin
    if (reset) begin
      x0       <= '0;
      x1       <= '0;
      x2       <= '0;
      hist_cnt <= '0;
    end else if (sample_valid) begin
      x2 <= x1;
      x1 <= x0;
      x0 <= sample_in;
      if (hist_cnt != 2'd2) hist_cnt <= hist_cnt + 2'd1;
    end
  end

  // S2 and S3 arithmetic
  always_comb begin
    x0e = {{18{x0[15]}}, x0};
    x1e = {{18{x1[15]}}, x1};
    x2e = {{18{x2[15]}}, x2};
    // |psi| stays below 2^31, so 34-bit wrap-around products are exact.
    sq      = x1e * x1e;
    cr      = x0e * x2e;
    psi_raw = sq - cr;
    psi_clamp = psi_raw[33] ? 32'd0 : psi_raw[31:0];

    // Threshold uses the mean before the current psi is folded in.
    acc_sh    = acc >> MEAN_SHIFT;
    mean      = acc_sh[31:0];
    thr_prod  = 40'(mean) * 40'(thresh_scale_in);
    thr       = thr_prod >> 2;
    floor40   = {24'd0, min_thresh_in};
    threshold = (thr > floor40) ? thr : floor40;
    candidate = ({8'd0, psi_q} > threshold);

    warm_done = (warm_cnt == WARM_W'(WARMUP_LEN));
    detect    = candidate && warm_done && (refr_cnt == 16'd0);
    acc_next  = acc - acc_sh + {8'd0, psi_q};
  end

  assign unused_ok = psi_raw[32];

  always_ff @(posedge clk) begin
    if (reset)            psi_q <= '0;
    else if (vld_pipe[1]) psi_q <= psi_clamp;
  end

  // S3: compare, refractory, running mean, outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      acc               <= '0;
      warm_cnt          <= '0;
      refr_cnt          <= '0;
      current_detection <= 1'b0;
      neo_energy        <= '0;
    end else begin
      current_detection <= 1'b0;
      if (vld_pipe[2]) begin
        neo_energy        <= psi_q;
        current_detection <= detect;
        acc               <= acc_next;
        if (!warm_done) warm_cnt <= warm_cnt + WARM_W'(1);
        // Suppressed candidates neither reload nor stall the countdown.
        if (detect)                 refr_cnt <= refractory_in;
        else if (refr_cnt != 16'd0) refr_cnt <= refr_cnt - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_neo_spike_detector.sv
// Scoreboard bench for neo_spike_detector: a reference model runs on every
// driven sample and queues the expected output with its due cycle; a
// negedge monitor pops and compares whenever the DUT raises neo_valid.

module tb_neo_spike_detector;

  localparam int MS = 8;
  localparam int WL = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic [7:0]  thresh_scale_in;
  logic [15:0] min_thresh_in;
  logic [15:0] refractory_in;
  logic        current_detection;
  logic [31:0] neo_energy;
  logic        neo_valid;

  neo_spike_detector #(.MEAN_SHIFT(MS), .WARMUP_LEN(WL)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .thresh_scale_in(thresh_scale_in), .min_thresh_in(min_thresh_in),
    .refractory_in(refractory_in), .current_detection(current_detection),
    .neo_energy(neo_energy), .neo_valid(neo_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] energy;
    logic        det;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_det = 0;

  // reference model state
  longint macc, mx0, mx1, mx2;
  int     mwarm, mref, mcnt;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    macc = 0; mx0 = 0; mx1 = 0; mx2 = 0;
    mwarm = 0; mref = 0; mcnt = 0;
  endtask

  task automatic model_step(input logic [15:0] v, input int due);
    longint psi, mean, thr, th;
    bit     det;
    exp_t   e;
    mx2 = mx1; mx1 = mx0; mx0 = longint'($signed(v));
    if (mcnt < 3) mcnt++;
    if (mcnt >= 3) begin
      psi = mx1 * mx1 - mx0 * mx2;
      if (psi < 0) psi = 0;
      mean = (macc >> MS) & 64'hFFFF_FFFF;
      thr  = (mean * longint'(thresh_scale_in)) >> 2;
      th   = (thr > longint'(min_thresh_in)) ? thr : longint'(min_thresh_in);
      det  = (psi > th) && (mwarm >= WL) && (mref == 0);
      if (det) mref = int'(refractory_in);
      else if (mref > 0) mref--;
      if (mwarm < WL) mwarm++;
      macc = (macc - (macc >> MS) + psi) & ((64'd1 << 40) - 1);
      e.due = due; e.energy = psi[31:0]; e.det = det;
      sb.push_back(e);
    end
  endtask

  task automatic send(input int v);
    @(posedge clk); #1;
    sample_in = 16'(v);
    sample_valid = 1'b1;
    model_step(16'(v), cyc + 3);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      sample_valid = 1'b0;
    end
  endtask

  task automatic cfg(input int scale, input int mn, input int refr);
    thresh_scale_in = 8'(scale);
    min_thresh_in   = 16'(mn);
    refractory_in   = 16'(refr);
  endtask

  // The reset cycle also offers a sample, which must be ignored.
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    sample_valid = 1'b1;
    sample_in = 16'd1234;
    while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
    model_clear();
    @(posedge clk); #1;
    sample_valid = 1'b0;
    chk("rst_det", current_detection, 0);
    chk("rst_valid", neo_valid, 0);
    chk("rst_energy", neo_energy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (current_detection && !neo_valid) chk("det_without_valid", 1, 0);
    if (neo_valid) begin
      if (current_detection) n_det++;
      if (sb.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        e = sb.pop_front();
        chk("latency", cyc, e.due);
        chk("energy", neo_energy, e.energy);
        chk("detect", current_detection, e.det);
      end
    end else if (sb.size() > 0 && sb[0].due < cyc) begin
      chk("missing_valid", cyc, sb[0].due);
      void'(sb.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, v;
    reset = 1'b1;
    sample_valid = 1'b1;
    sample_in = 16'd777;
    cfg(8, 100, 0);
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("init_det", current_detection, 0);
    chk("init_valid", neo_valid, 0);
    chk("init_energy", neo_energy, 0);
    sample_valid = 1'b0;
    reset = 1'b0;

    // constant input: psi identically zero
    base = n_det;
    repeat (400) send(1000);
    idle(5);
    chk("const_detections", n_det - base, 0);

    // single impulse after warm-up
    do_reset();
    base = n_det;
    repeat (300) send(0);
    send(0); send(50); send(0); send(0);
    idle(5);
    chk("impulse_detections", n_det - base, 1);

    // negative psi clamps to zero
    cfg(8, 20000, 0);
    base = n_det;
    send(100); send(0); send(100); send(0);
    idle(5);
    chk("neg_psi_detections", n_det - base, 0);

    // refractory lockout spanning the second impulse
    cfg(8, 100, 10);
    base = n_det;
    repeat (20) send(0);
    send(50); repeat (4) send(0); send(50);
    repeat (20) send(0);
    idle(5);
    chk("refr10_detections", n_det - base, 1);

    cfg(8, 100, 2);
    base = n_det;
    repeat (20) send(0);
    send(50); repeat (4) send(0); send(50);
    repeat (20) send(0);
    idle(5);
    chk("refr2_detections", n_det - base, 2);

    // warm-up gating: impulse early is suppressed, later one fires
    cfg(8, 100, 0);
    do_reset();
    base = n_det;
    repeat (201) send(0);
    send(50);
    repeat (98) send(0);
    send(50);
    repeat (5) send(0);
    idle(5);
    chk("warmup_detections", n_det - base, 1);

    // psi equal to threshold must not detect; one above must
    cfg(0, 2500, 0);
    base = n_det;
    repeat (5) send(0);
    send(50); repeat (3) send(0);
    idle(5);
    chk("equal_thresh_detections", n_det - base, 0);
    base = n_det;
    send(51); repeat (3) send(0);
    idle(5);
    chk("above_thresh_detections", n_det - base, 1);

    // spiky random stream with gaps, adaptive threshold active
    cfg(12, 500, 3);
    repeat (300) begin
      if ($urandom_range(0, 9) == 0) v = int'($urandom_range(1000, 4000));
      else v = int'($urandom_range(0, 200));
      if ($urandom_range(0, 1) == 1) v = -v;
      send(v);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(6);

    // reset one clk after the impulse completes: in-flight data discarded
    cfg(8, 100, 0);
    repeat (10) send(0);
    base = n_det;
    send(0); send(50); send(0);
    do_reset();
    send(5); send(6);
    idle(6);
    chk("midreset_detections", n_det - base, 0);
    chk("post_reset_energy", neo_energy, 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
